// File: rtl/skintone_stream_ctrl_pkg.sv
// skintone_stream_ctrl_pkg: shared widths, pixel layout, flush FSM states and pointer helper
package skintone_stream_ctrl_pkg;
   localparam int PIXEL_W      = 24;
   localparam int SCORE_W      = 8;
   localparam int PIPE_LAT_DEF = 16;
   typedef struct packed {
      logic [7:0] y;
      logic [7:0] cr;
      logic [7:0] cb;
   } pixel_t;
   typedef enum logic {ST_FLUSH, ST_RUN} state_e;
   function automatic int unsigned ptr_inc(input int unsigned p, input int unsigned depth);
      return (p + 1 == depth) ? 0 : p + 1;
   endfunction
endpackage

// File: rtl/skintone_stream_ctrl_if.sv
// skintone_stream_ctrl_if: valid/ready stream bundle; carries last when SKINTONE_LAST_EN is defined
interface skintone_stream_ctrl_if #(parameter int W = skintone_stream_ctrl_pkg::PIXEL_W);
   logic [W-1:0] data;
   logic         valid;
   logic         ready;
`ifdef SKINTONE_LAST_EN
   logic         last;
   modport master (output data, valid, last, input ready);
   modport slave (input data, valid, last, output ready);
`else
   modport master (output data, valid, input ready);
   modport slave (input data, valid, output ready);
`endif
endinterface

// File: rtl/skintone_result_fifo.sv
// skintone_result_fifo: first-word fall-through result FIFO of any depth >= 2
module skintone_result_fifo
   import skintone_stream_ctrl_pkg::*;
#(
   parameter int W     = 8,
   parameter int DEPTH = 32,
   localparam int PW   = $clog2(DEPTH),
   localparam int LW   = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [W-1:0]  wdata,
   input  logic          pop,
   output logic [W-1:0]  rdata,
   output logic [LW-1:0] level,
   output logic          full,
   output logic          empty
);
   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          wr_en, rd_en;

   assign full  = level_q == LW'(DEPTH);
   assign empty = level_q == '0;
   assign level = level_q;
   assign rdata = empty ? '0 : mem_q[rd_ptr_q];

   // pointer and occupancy updates; a push into a full FIFO is dropped
   always_comb begin
      wr_en    = push && !full;
      rd_en    = pop && !empty;
      wr_ptr_d = wr_en ? PW'(ptr_inc(32'(wr_ptr_q), DEPTH)) : wr_ptr_q;
      rd_ptr_d = rd_en ? PW'(ptr_inc(32'(rd_ptr_q), DEPTH)) : rd_ptr_q;
      level_d  = level_q + LW'(wr_en) - LW'(rd_en);
   end

   // storage needs no reset; the head is masked while empty
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= wdata;
   end

   // pointer and level registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end
endmodule

// File: rtl/skintone_stream_ctrl.sv
// skintone_stream_ctrl: issues pixels to a non-stalling datapath against reserved result FIFO space; SKINTONE_LAST_EN adds last flags
module skintone_stream_ctrl
   import skintone_stream_ctrl_pkg::*;
#(
   parameter int PIPE_LAT   = PIPE_LAT_DEF,
   parameter int FIFO_DEPTH = 32,
   localparam int LW        = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   skintone_stream_ctrl_if.slave  s,
   skintone_stream_ctrl_if.master m,
   output pixel_t                dp_pixel,
   output logic                  dp_valid,
   input  logic [SCORE_W-1:0]    dp_result,
   input  logic                  dp_result_valid,
   output logic [LW-1:0]         fifo_level,
   output logic                  ovf_err
);
   localparam int CW = $clog2(PIPE_LAT + 2);
`ifdef SKINTONE_LAST_EN
   localparam int FW  = SCORE_W + 1;
   localparam int SRW = PIPE_LAT + 1;
   logic [SRW-1:0] last_sr_q, last_sr_d;
`else
   localparam int FW  = SCORE_W;
`endif

   state_e        state_q, state_d;
   logic [CW-1:0] flush_cnt_q, flush_cnt_d;
   logic [LW-1:0] used_q, used_d;
   pixel_t        dp_pixel_q, dp_pixel_d;
   logic          dp_valid_q, dp_valid_d, ovf_err_q, ovf_err_d;
   logic          flush, accept, pop, push, fifo_full, fifo_empty;
   logic [FW-1:0] fifo_wdata, fifo_rdata;

   if (FIFO_DEPTH < 2) begin : g_depth_chk
      $error("skintone_stream_ctrl: FIFO_DEPTH must be at least 2");
   end

   assign flush    = state_q == ST_FLUSH;
   assign s.ready  = !flush && (used_q < LW'(FIFO_DEPTH));
   assign accept   = s.valid && s.ready;
   assign pop      = m.valid && m.ready;
   assign push     = dp_result_valid && !flush;
   assign dp_pixel = dp_pixel_q;
   assign dp_valid = dp_valid_q;
   assign ovf_err  = ovf_err_q;
   assign m.valid  = !fifo_empty;
   assign m.data   = fifo_rdata[SCORE_W-1:0];
`ifdef SKINTONE_LAST_EN
   assign fifo_wdata = {last_sr_q[PIPE_LAT], dp_result};
   assign m.last     = fifo_rdata[SCORE_W];
`else
   assign fifo_wdata = dp_result;
`endif

   // flush sequencing, reservation count, issue register and sticky overflow
   always_comb begin
      state_d     = (flush && flush_cnt_q == CW'(1)) ? ST_RUN : state_q;
      flush_cnt_d = flush ? flush_cnt_q - 1'b1 : flush_cnt_q;
      used_d      = used_q + LW'(accept) - LW'(pop);
      dp_valid_d  = accept;
      dp_pixel_d  = accept ? pixel_t'(s.data) : dp_pixel_q;
      ovf_err_d   = ovf_err_q || (push && fifo_full);
`ifdef SKINTONE_LAST_EN
      last_sr_d   = flush ? '0 : (last_sr_q << 1) | SRW'(accept && s.last);
`endif
   end

   // control registers; reset re-enters FLUSH with nothing reserved
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_FLUSH;
         flush_cnt_q <= CW'(PIPE_LAT + 1);
         used_q      <= '0;
         dp_valid_q  <= 1'b0;
         dp_pixel_q  <= '0;
         ovf_err_q   <= 1'b0;
`ifdef SKINTONE_LAST_EN
         last_sr_q   <= '0;
`endif
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
         used_q      <= used_d;
         dp_valid_q  <= dp_valid_d;
         dp_pixel_q  <= dp_pixel_d;
         ovf_err_q   <= ovf_err_d;
`ifdef SKINTONE_LAST_EN
         last_sr_q   <= last_sr_d;
`endif
      end
   end

   skintone_result_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .wdata (fifo_wdata),
      .pop   (pop),
      .rdata (fifo_rdata),
      .level (fifo_level),
      .full  (fifo_full),
      .empty (fifo_empty)
   );
endmodule

// File: tb/tb_skintone_stream_ctrl.sv
// tb_skintone_stream_ctrl: randomized bench with a 16-cycle datapath model and an end-to-end score scoreboard
`timescale 1ns/1ps
module tb_skintone_stream_ctrl;
   localparam int LAT   = 16;
   localparam int DEPTH = 32;
`ifdef SKINTONE_LAST_EN
   localparam bit HAS_LAST = 1'b1;
`else
   localparam bit HAS_LAST = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [23:0] dp_pixel;
   logic        dp_valid;
   logic [7:0]  dp_result;
   logic        dp_result_valid;
   logic [5:0]  fifo_level;
   logic        ovf_err;
   logic [LAT-1:0] pv = '1;
   logic [7:0]  pd [LAT];
   logic [8:0]  exp_q [$];
   int          n_tests = 0;
   int          n_fail = 0;

   skintone_stream_ctrl_if #(.W(24)) s_if ();
   skintone_stream_ctrl_if #(.W(8))  m_if ();

   skintone_stream_ctrl #(.PIPE_LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .s               (s_if),
      .m               (m_if),
      .dp_pixel        (dp_pixel),
      .dp_valid        (dp_valid),
      .dp_result       (dp_result),
      .dp_result_valid (dp_result_valid),
      .fifo_level      (fifo_level),
      .ovf_err         (ovf_err)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] score_of(input logic [23:0] p);
      return (p[23:16] ^ p[7:0]) + {p[15:9], 1'b1};
   endfunction

   // unreset datapath model: starts full of stale valids, fixed latency LAT
   always @(posedge clk) begin
      pv <= {pv[LAT-2:0], dp_valid};
      pd[0] <= score_of(dp_pixel);
      for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
   end
   assign dp_result_valid = pv[LAT-1];
   assign dp_result       = pd[LAT-1];

   function automatic logic m_last_now();
`ifdef SKINTONE_LAST_EN
      return m_if.last;
`else
      return 1'b0;
`endif
   endfunction

   // one cycle: drive at the falling edge, record handshakes, advance past the rising edge
   task automatic step(input logic sv, input logic [23:0] px, input logic sl, input logic mr,
                       output logic acc, output logic pop, output logic [8:0] got);
      s_if.valid  = sv;
      s_if.data   = px;
      m_if.ready  = mr;
`ifdef SKINTONE_LAST_EN
      s_if.last   = sl;
`endif
      acc = sv && s_if.ready;
      pop = m_if.valid && mr;
      got = {m_last_now(), m_if.data};
      if (acc) exp_q.push_back({sl & HAS_LAST, score_of(px)});
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      logic acc, pop;
      logic [8:0] got;
      int n = 0;
      rst_n = 1'b0;
      s_if.valid = 1'b0;
      m_if.ready = 1'b0;
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      while (!s_if.ready && n < 40) begin
         step(1'b0, 24'h0, 1'b0, 1'b0, acc, pop, got);
         n++;
      end
      n_tests++;
      if (s_if.ready !== 1'b1) begin n_fail++; $display("FAIL flush_exit s_ready=%b after %0d cycles, required 1", s_if.ready, n); end
   endtask

   task automatic test_reset();
      logic acc, pop;
      logic [8:0] got, want;
      int first_acc = 0, pops = 0;
      bit stale = 0;
      #1;
      n_tests++; if (s_if.ready !== 1'b0) begin n_fail++; $display("FAIL rst_s_ready got %b want 0", s_if.ready); end
      n_tests++; if (dp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_dp_valid got %b want 0", dp_valid); end
      n_tests++; if (dp_pixel !== 24'h0) begin n_fail++; $display("FAIL rst_dp_pixel got %h want 0", dp_pixel); end
      n_tests++; if (m_if.valid !== 1'b0) begin n_fail++; $display("FAIL rst_m_valid got %b want 0", m_if.valid); end
      n_tests++; if (m_if.data !== 8'h0) begin n_fail++; $display("FAIL rst_m_score got %h want 0", m_if.data); end
      n_tests++; if (fifo_level !== 6'd0) begin n_fail++; $display("FAIL rst_fifo_level got %0d want 0", fifo_level); end
      n_tests++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL rst_ovf_err got %b want 0", ovf_err); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int n = 1; n <= 40 && first_acc == 0; n++) begin
         if (m_if.valid || fifo_level != 0) stale = 1;
         step(1'b1, 24'h3c9a71 + 24'(n), 1'b0, 1'b0, acc, pop, got);
         if (acc) first_acc = n;
      end
      n_tests++; if (first_acc != LAT + 2) begin n_fail++; $display("FAIL first_accept_edge got %0d want %0d", first_acc, LAT + 2); end
      n_tests++; if (stale) begin n_fail++; $display("FAIL flush_stale_push got 1 want 0"); end
      for (int n = 0; n < 40 && pops == 0; n++) begin
         step(1'b0, 24'h0, 1'b0, 1'b1, acc, pop, got);
         if (pop) begin
            pops++;
            want = exp_q.size() != 0 ? exp_q.pop_front() : 9'bx;
            n_tests++; if (got !== want) begin n_fail++; $display("FAIL first_score got %h want %h", got, want); end
         end
      end
      n_tests++; if (pops != 1) begin n_fail++; $display("FAIL first_score_count got %0d want 1", pops); end
   endtask

   task automatic test_back_to_back();
      logic acc, pop;
      logic [8:0] got, want;
      int a0 = -1, v0 = -1, acc_n = 0, pops = 0, drops = 0;
      do_reset();
      for (int n = 0; n < 400 && pops < 100; n++) begin
         if (v0 < 0 && m_if.valid) v0 = n;
         if (acc_n < 100 && !s_if.ready) drops++;
         step(acc_n < 100, 24'($urandom), (acc_n % 8) == 7, 1'b1, acc, pop, got);
         if (acc) begin
            if (a0 < 0) a0 = n;
            acc_n++;
         end
         if (pop) begin
            pops++;
            want = exp_q.size() != 0 ? exp_q.pop_front() : 9'bx;
            n_tests++; if (got !== want) begin n_fail++; $display("FAIL b2b_score #%0d got %h want %h", pops, got, want); end
         end
      end
      n_tests++; if (v0 - a0 != LAT + 2) begin n_fail++; $display("FAIL b2b_latency got %0d want %0d", v0 - a0, LAT + 2); end
      n_tests++; if (drops != 0) begin n_fail++; $display("FAIL b2b_ready_drops got %0d want 0", drops); end
      n_tests++; if (pops != 100) begin n_fail++; $display("FAIL b2b_count got %0d want 100", pops); end
   endtask

   task automatic test_backpressure();
      logic acc, pop;
      logic [8:0] got, want;
      int acc_n = 0, pops = 0;
      do_reset();
      for (int n = 0; n < 70; n++) begin
         step(1'b1, 24'($urandom), (acc_n % 8) == 7, 1'b0, acc, pop, got);
         if (acc) acc_n++;
      end
      n_tests++; if (acc_n != DEPTH) begin n_fail++; $display("FAIL bp_accepts got %0d want %0d", acc_n, DEPTH); end
      n_tests++; if (s_if.ready !== 1'b0) begin n_fail++; $display("FAIL bp_s_ready_full got %b want 0", s_if.ready); end
      n_tests++; if (fifo_level !== 6'(DEPTH)) begin n_fail++; $display("FAIL bp_fifo_level got %0d want %0d", fifo_level, DEPTH); end
      n_tests++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL bp_ovf_err got %b want 0", ovf_err); end
      step(1'b0, 24'h0, 1'b0, 1'b1, acc, pop, got);
      n_tests++; if (s_if.ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_pop got %b want 1", s_if.ready); end
      if (pop) pops++;
      want = exp_q.size() != 0 ? exp_q.pop_front() : 9'bx;
      n_tests++; if (!pop || got !== want) begin n_fail++; $display("FAIL bp_first_pop got %b/%h want 1/%h", pop, got, want); end
      for (int n = 0; n < 100 && pops < DEPTH; n++) begin
         step(1'b0, 24'h0, 1'b0, 1'($urandom_range(1)), acc, pop, got);
         if (pop) begin
            pops++;
            want = exp_q.size() != 0 ? exp_q.pop_front() : 9'bx;
            n_tests++; if (got !== want) begin n_fail++; $display("FAIL bp_score #%0d got %h want %h", pops, got, want); end
         end
      end
      n_tests++; if (pops != DEPTH) begin n_fail++; $display("FAIL bp_drain_count got %0d want %0d", pops, DEPTH); end
   endtask

   task automatic test_random();
      logic acc, pop;
      logic [8:0] got, want;
      int acc_n = 0, pops = 0, used = 0, max_used = 0, viol = 0;
      do_reset();
      for (int n = 0; n < 80000 && pops < 10000; n++) begin
         if (s_if.ready !== (used < DEPTH)) viol++;
         if (fifo_level > 6'(DEPTH)) viol++;
         step(acc_n < 10000 && 1'($urandom_range(1)), 24'($urandom), (acc_n % 8) == 7,
              1'($urandom_range(1)), acc, pop, got);
         used += int'(acc) - int'(pop);
         if (used > max_used) max_used = used;
         if (acc) acc_n++;
         if (pop) begin
            pops++;
            want = exp_q.size() != 0 ? exp_q.pop_front() : 9'bx;
            n_tests++; if (got !== want) begin n_fail++; $display("FAIL rand_score #%0d got %h want %h", pops, got, want); end
         end
      end
      n_tests++; if (pops != 10000) begin n_fail++; $display("FAIL rand_count got %0d want 10000", pops); end
      n_tests++; if (viol != 0) begin n_fail++; $display("FAIL rand_s_ready_rule got %0d violations want 0", viol); end
      n_tests++; if (max_used > DEPTH) begin n_fail++; $display("FAIL rand_used_max got %0d want <= %0d", max_used, DEPTH); end
      n_tests++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL rand_ovf_err got %b want 0", ovf_err); end
   endtask

   task automatic test_reset_mid();
      logic acc, pop;
      logic [8:0] got, want;
      int acc_n = 0, pops = 0;
      bit stale = 0;
      do_reset();
      for (int n = 0; n < 80 && fifo_level != 6'd10; n++) step(1'b1, 24'($urandom), 1'b0, 1'b0, acc, pop, got);
      n_tests++; if (fifo_level !== 6'd10) begin n_fail++; $display("FAIL mid_fill got %0d want 10", fifo_level); end
      rst_n = 1'b0;
      #1;
      n_tests++; if (m_if.valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_m_valid got %b want 0", m_if.valid); end
      n_tests++; if (fifo_level !== 6'd0) begin n_fail++; $display("FAIL mid_rst_level got %0d want 0", fifo_level); end
      n_tests++; if (s_if.ready !== 1'b0 || dp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ctrl got s_ready=%b dp_valid=%b want 0/0", s_if.ready, dp_valid); end
      do_reset();
      for (int n = 0; n < 40; n++) begin
         if (m_if.valid) stale = 1;
         step(1'b0, 24'h0, 1'b0, 1'b1, acc, pop, got);
      end
      n_tests++; if (stale) begin n_fail++; $display("FAIL mid_stale_score got 1 want 0"); end
      for (int n = 0; n < 60 && pops < 5; n++) begin
         step(acc_n < 5, 24'($urandom), 1'b0, 1'b1, acc, pop, got);
         if (acc) acc_n++;
         if (pop) begin
            pops++;
            want = exp_q.size() != 0 ? exp_q.pop_front() : 9'bx;
            n_tests++; if (got !== want) begin n_fail++; $display("FAIL mid_after_score #%0d got %h want %h", pops, got, want); end
         end
      end
      n_tests++; if (pops != 5) begin n_fail++; $display("FAIL mid_after_count got %0d want 5", pops); end
   endtask

`ifdef SKINTONE_LAST_EN
   task automatic test_last();
      logic acc, pop;
      logic [8:0] got, want;
      int acc_n = 0, pops = 0, lasts = 0;
      do_reset();
      for (int n = 0; n < 600 && pops < 64; n++) begin
         step(acc_n < 64, 24'($urandom), (acc_n % 8) == 7, 1'($urandom_range(1)), acc, pop, got);
         if (acc) acc_n++;
         if (pop) begin
            pops++;
            if (got[8]) lasts++;
            want = exp_q.size() != 0 ? exp_q.pop_front() : 9'bx;
            n_tests++; if (got !== want) begin n_fail++; $display("FAIL last_score #%0d got %h want %h", pops, got, want); end
         end
      end
      n_tests++; if (pops != 64 || lasts != 8) begin n_fail++; $display("FAIL last_count got %0d/%0d want 64/8", pops, lasts); end
   endtask
`endif

   initial begin
      s_if.valid = 1'b0;
      s_if.data  = 24'h0;
      m_if.ready = 1'b0;
`ifdef SKINTONE_LAST_EN
      s_if.last  = 1'b0;
`endif
      test_reset();
      test_back_to_back();
      test_backpressure();
      test_random();
      test_reset_mid();
`ifdef SKINTONE_LAST_EN
      test_last();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
